// File: rtl/hamming74_decode_fifo.sv
// Hamming(7,4) decoder with single-bit correction feeding a small ready/valid FIFO.
// Codewords pass through one stage register, so a nibble is visible two edges after its strobe.
module hamming74_decode_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [6:0] code_in,
  input  logic       code_valid,
  input  logic       out_ready,
  output logic [3:0] data_out,
  output logic       corrected_out,
  output logic       out_valid,
  output logic       full,
  output logic       overflow,
  output logic [7:0] err_count
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [6:0]       code_reg;
  logic             stage_valid_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             overflow_reg;
  logic [7:0]       err_count_reg;

  logic [3:0] mem_data [DEPTH];
  logic       mem_corr [DEPTH];

  logic [2:0] syndrome;
  logic [6:0] flip_mask;
  logic [6:0] fixed_code;
  logic [3:0] dec_nibble;
  logic       dec_corrected;
  logic       pop;
  logic       push_req;
  logic       wr_ok;
  logic       drop;

  always_comb begin
    syndrome[0] = code_reg[0] ^ code_reg[2] ^ code_reg[4] ^ code_reg[6];
    syndrome[1] = code_reg[1] ^ code_reg[2] ^ code_reg[5] ^ code_reg[6];
    syndrome[2] = code_reg[3] ^ code_reg[4] ^ code_reg[5] ^ code_reg[6];
    flip_mask   = 7'd0;
    if (syndrome != 3'd0) begin
      flip_mask = 7'd1 << (syndrome - 3'd1);
    end
    fixed_code    = code_reg ^ flip_mask;
    dec_nibble    = {fixed_code[6], fixed_code[5], fixed_code[4], fixed_code[2]};
    dec_corrected = (syndrome != 3'd0);
  end

  assign out_valid = (count_reg != '0);
  assign full      = (count_reg == DEPTH_C);
  assign overflow  = overflow_reg;
  assign err_count = err_count_reg;

  // A pop only happens on a non-empty FIFO, which frees the slot a full-FIFO write needs.
  assign pop      = ena & out_valid & out_ready;
  assign push_req = ena & stage_valid_reg;
  assign wr_ok    = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  assign data_out      = out_valid ? mem_data[rd_ptr_reg] : 4'd0;
  assign corrected_out = out_valid ? mem_corr[rd_ptr_reg] : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_reg        <= '0;
      stage_valid_reg <= 1'b0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      overflow_reg    <= 1'b0;
      err_count_reg   <= '0;
    end else if (ena) begin
      stage_valid_reg <= code_valid;
      if (code_valid) begin
        code_reg <= code_in;
      end
      if (wr_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (wr_ok && !pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop && !wr_ok) begin
        count_reg <= count_reg - 1'b1;
      end
      if (drop) begin
        overflow_reg <= 1'b1;
      end
      if (wr_ok && dec_corrected && err_count_reg != 8'hFF) begin
        err_count_reg <= err_count_reg + 8'd1;
      end
    end
  end

  // Storage carries no reset; the occupancy count alone decides what is visible.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_data[wr_ptr_reg] <= dec_nibble;
      mem_corr[wr_ptr_reg] <= dec_corrected;
    end
  end

endmodule

// File: tb/tb_hamming74_decode_fifo.sv
// Directed bench for hamming74_decode_fifo: clean/corrected words, overflow, full-with-pop,
// enable gating, counter saturation and asynchronous reset.
module tb_hamming74_decode_fifo;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [6:0] code_in;
  logic       code_valid;
  logic       out_ready;
  logic [3:0] data_out;
  logic       corrected_out;
  logic       out_valid;
  logic       full;
  logic       overflow;
  logic [7:0] err_count;

  int n_cmp = 0;
  int n_err = 0;

  hamming74_decode_fifo #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .code_in(code_in),
    .code_valid(code_valid),
    .out_ready(out_ready),
    .data_out(data_out),
    .corrected_out(corrected_out),
    .out_valid(out_valid),
    .full(full),
    .overflow(overflow),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [6:0] cw);
    code_in    = cw;
    code_valid = 1'b1;
    step();
    code_valid = 1'b0;
  endtask

  logic [6:0] seq_codes [5];
  logic [3:0] exp_nib   [4];

  initial begin
    rst_n = 1'b0; ena = 1'b1; code_in = '0; code_valid = 1'b0; out_ready = 1'b0;
    #2;
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_full", full, 0);
    check_eq("rst_data", data_out, 0);
    check_eq("rst_corr", corrected_out, 0);
    check_eq("rst_ovf", overflow, 0);
    check_eq("rst_err", err_count, 0);
    #20 rst_n = 1'b1;
    step();

    // clean word: 7'h55 decodes to 4'hB with no correction
    out_ready = 1'b1;
    strobe(7'h55);
    check_eq("clean_lat1", out_valid, 0);
    step();
    $display("txn clean code=55 data=%0h corr=%0b", data_out, corrected_out);
    check_eq("clean_valid", out_valid, 1);
    check_eq("clean_data", data_out, 4'hB);
    check_eq("clean_corr", corrected_out, 0);
    check_eq("clean_err", err_count, 0);
    step();
    check_eq("clean_popped", out_valid, 0);

    // every single-bit flip of 7'h55 must still decode to 4'hB
    for (int i = 0; i < 7; i++) begin
      strobe(7'h55 ^ (7'd1 << i));
      step();
      $display("txn flip bit=%0d data=%0h corr=%0b err=%0d", i, data_out, corrected_out, err_count);
      check_eq($sformatf("flip%0d_data", i), data_out, 4'hB);
      check_eq($sformatf("flip%0d_corr", i), corrected_out, 1);
      check_eq($sformatf("flip%0d_err", i), err_count, i + 1);
      step();
    end

    // full FIFO with a write coinciding with a pop: nothing dropped
    out_ready = 1'b0;
    seq_codes[0] = 7'h07; seq_codes[1] = 7'h19; seq_codes[2] = 7'h1E;
    seq_codes[3] = 7'h2A; seq_codes[4] = 7'h2D;
    for (int k = 0; k < 5; k++) begin
      code_in = seq_codes[k];
      code_valid = 1'b1;
      step();
    end
    code_valid = 1'b0;
    check_eq("fp_full_before", full, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("fp_ovf", overflow, 0);
    check_eq("fp_full_after", full, 1);
    exp_nib[0] = 4'h2; exp_nib[1] = 4'h3; exp_nib[2] = 4'h4; exp_nib[3] = 4'h5;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      $display("txn fp drain %0d data=%0h", k, data_out);
      check_eq($sformatf("fp_drain%0d_valid", k), out_valid, 1);
      check_eq($sformatf("fp_drain%0d_data", k), data_out, exp_nib[k]);
      step();
    end
    check_eq("fp_empty", out_valid, 0);

    // fill with 4 x 7'h00, then 7'h55 is dropped
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      code_in = (k < 4) ? 7'h00 : 7'h55;
      code_valid = 1'b1;
      step();
    end
    code_valid = 1'b0;
    step();
    check_eq("ov_full", full, 1);
    check_eq("ov_flag", overflow, 1);
    check_eq("ov_err", err_count, 7);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      $display("txn ov drain %0d data=%0h", k, data_out);
      check_eq($sformatf("ov_drain%0d_valid", k), out_valid, 1);
      check_eq($sformatf("ov_drain%0d_data", k), data_out, 4'h0);
      step();
    end
    check_eq("ov_empty", out_valid, 0);
    check_eq("ov_sticky", overflow, 1);

    // ena gating: strobe and pop ignored while ena is low
    out_ready = 1'b0;
    strobe(7'h55);
    step();
    check_eq("ena_pre_valid", out_valid, 1);
    ena = 1'b0; code_in = 7'h07; code_valid = 1'b1; out_ready = 1'b1;
    step(); step(); step();
    code_valid = 1'b0;
    $display("txn ena_low valid=%0b data=%0h", out_valid, data_out);
    check_eq("ena_hold_valid", out_valid, 1);
    check_eq("ena_hold_data", data_out, 4'hB);
    check_eq("ena_hold_full", full, 0);
    ena = 1'b1;
    step();
    check_eq("ena_resume_pop", out_valid, 0);
    step();
    check_eq("ena_lost_strobe", out_valid, 0);
    out_ready = 1'b0;
    strobe(7'h07);
    step();
    check_eq("ena_resume_data", data_out, 4'h1);
    out_ready = 1'b1;
    step();
    check_eq("ena_resume_empty", out_valid, 0);

    // saturation: 260 corrected words
    for (int k = 0; k < 260; k++) begin
      code_in = 7'h45;
      code_valid = 1'b1;
      step();
    end
    code_valid = 1'b0;
    step(); step();
    $display("txn saturate err=%0d", err_count);
    check_eq("sat_err", err_count, 8'd255);
    check_eq("sat_empty", out_valid, 0);

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    strobe(7'h55);
    strobe(7'h07);
    code_in = 7'h19; code_valid = 1'b1;
    step();
    code_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_valid", out_valid, 0);
    check_eq("arst_data", data_out, 0);
    check_eq("arst_corr", corrected_out, 0);
    check_eq("arst_full", full, 0);
    check_eq("arst_ovf", overflow, 0);
    check_eq("arst_err", err_count, 0);
    #10 rst_n = 1'b1;
    step(); step();
    check_eq("arst_post_empty", out_valid, 0);
    check_eq("arst_post_err", err_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hamming74_decode_fifo.md
Name: hamming74_decode_fifo

Overview:
Downstream consumer of the UART receiver. Takes each 7-bit Hamming(7,4) codeword delivered with the receiver's one-cycle valid pulse, corrects any single-bit error, and buffers the recovered 4-bit nibbles in a small FIFO. The FIFO drains over a ready/valid handshake to the application side. The block also reports per-nibble correction status, a saturating corrected-error count, and a sticky overflow flag.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
PTR_W, 2, log2(DEPTH).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  global enable; when low, all registers hold
code_in  in  7  codeword from the receiver, cw[6:0]
code_valid  in  1  one-cycle strobe; code_in is valid
out_ready  in  1  consumer accepts the head entry
data_out  out  4  head nibble {d3,d2,d1,d0}
corrected_out  out  1  head entry had a single-bit correction applied
out_valid  out  1  FIFO not empty
full  out  1  FIFO holds DEPTH entries
overflow  out  1  sticky; a codeword was dropped
err_count  out  8  saturating count of corrected codewords

Behaviour:
- Reset (asynchronous, rst_n low): FIFO empty, pointers 0, stage register cleared.
  - Output values: out_valid=0, full=0, data_out=0, corrected_out=0, overflow=0, err_count=0.
- ena low: no state changes.
  - code_valid and out_ready are ignored; the strobe is lost.
- Codeword layout uses 1-based position p = index+1.
  - Parity bits: cw[0]=P1, cw[1]=P2, cw[3]=P4.
  - Data bits: d0=cw[2], d1=cw[4], d2=cw[5], d3=cw[6].
- Syndrome:
  - s0 = cw0^cw2^cw4^cw6
  - s1 = cw1^cw2^cw5^cw6
  - s2 = cw3^cw4^cw5^cw6
  - S = {s2,s1,s0}.
  - S != 0: flip cw[S-1], set corrected=1.
  - S == 0: no correction, corrected=0.
  - Double errors are not detectable; they decode to a wrong nibble with corrected=1. This is accepted behaviour.
- Pipeline:
  - Edge E0: code_valid=1 latches code_in into the stage register and sets stage_valid.
  - Edge E1: the decoded nibble and corrected flag are written to the FIFO.
  - out_valid rises after E1 if the FIFO was empty, giving 2-cycle latency.
  - The stage register accepts a new codeword every cycle; back-to-back strobes are legal.
- Pop: out_valid & out_ready at an edge advances the read pointer.
  - data_out and corrected_out always reflect the head entry, combinationally from the registered FIFO.
  - When the FIFO is empty, data_out and corrected_out are 0.
- Write when full:
  - If a pop occurs in the same cycle, the write is accepted and the count is unchanged.
  - Otherwise the entry is dropped, overflow is set, and it stays set until reset.
- Simultaneous write and pop when empty: no pop occurs (out_valid=0); the write is accepted.
- err_count increments on each FIFO write with corrected=1 and saturates at 255.
  - Dropped entries are not counted.
- Pointers wrap modulo DEPTH. Occupancy is tracked with a PTR_W+1 count; full = (count==DEPTH).
- Reset mid-operation discards the stage register and all FIFO contents immediately.

Test Plan:
- Clean word: code_in=7'h55 with a strobe, out_ready=1 -> out_valid rises 2 edges later; data_out=4'hB, corrected_out=0, err_count=0.
- Single error: code_in=7'h45 (cw[4] flipped from 7'h55) -> data_out=4'hB, corrected_out=1, err_count=1; repeat with each of the 7 bit flips -> always 4'hB.
- Fill and overflow: out_ready=0, DEPTH+1 strobes of 7'h00 then 7'h55 -> full=1 and overflow=1 after the last write. Then drain with out_ready=1 -> DEPTH nibbles, first 4'h0, and the dropped 4'hB never appears.
- Full with simultaneous pop: FIFO full, strobe coinciding with a pop -> no overflow; the new nibble appears last in the drain order.
- ena gating: ena=0 during a strobe and with out_ready=1 -> FIFO unchanged and out_valid unchanged; ena=1 resumes normal operation.
- Saturation and reset: 260 corrected words with out_ready=1 -> err_count=255. Assert rst_n=0 mid-stream -> all outputs 0 immediately (asynchronously) and the FIFO is empty after release.
